// File: rtl/pwm_ramp_sequencer.sv
// Purpose: owns the PWM duty register and ramps it toward a target in clamped steps; SPI writes override.
// Latency: all outputs registered; a direct write appears one edge later, the first ramp step interval+1 edges after start is accepted.
// Backpressure: none; start is honoured only in IDLE, ext_wr_valid always wins over abort and start.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, abort        - begin a ramp (IDLE only) / stop an active ramp holding duty
//   target, step        - ramp end value and per-update increment (step 0 behaves as 1)
//   interval            - idle cycles between ramp updates
//   ext_wr_valid/_data  - direct duty write from the SPI register decoder
//   bounce              - only with PWM_RAMP_BOUNCE_EN defined: ramp back and forth until stopped
//   duty_out, busy, done- duty to PWM peripheral, ramp active, one-cycle completion pulse
// Optional feature macro: PWM_RAMP_BOUNCE_EN
module pwm_ramp_sequencer #(
    parameter int DUTY_W = 8,
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DUTY_W-1:0] target,
    input  logic [DUTY_W-1:0] step,
    input  logic [TICK_W-1:0] interval,
    input  logic              ext_wr_valid,
    input  logic [DUTY_W-1:0] ext_wr_data,
`ifdef PWM_RAMP_BOUNCE_EN
    input  logic              bounce,
`endif
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [TICK_W-1:0]   cnt_q, cnt_d;
    logic [DUTY_W-1:0]   tgt_q, tgt_d;
    logic [DUTY_W-1:0]   step_q, step_d;
    logic [TICK_W-1:0]   intv_q, intv_d;
`ifdef PWM_RAMP_BOUNCE_EN
    logic                bounce_q, bounce_d;
    logic [DUTY_W-1:0]   origin_q, origin_d;   // duty at the far end of the bounce
`endif

    // Gaps are taken one bit wider so the compare against step can never wrap.
    logic [DUTY_W:0]     up_gap;
    logic [DUTY_W:0]     dn_gap;
    logic [DUTY_W-1:0]   next_duty;

    always_comb begin
        up_gap = {1'b0, tgt_q} - {1'b0, duty_q};
        dn_gap = {1'b0, duty_q} - {1'b0, tgt_q};
        // When the gap exceeds step, duty +/- step stays strictly between duty and target,
        // so the plain DUTY_W-bit add/subtract below cannot wrap.
        if (tgt_q >= duty_q) begin
            next_duty = (up_gap <= {1'b0, step_q}) ? tgt_q : duty_q + step_q;
        end else begin
            next_duty = (dn_gap <= {1'b0, step_q}) ? tgt_q : duty_q - step_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        step_d   = step_q;
        intv_d   = intv_q;
`ifdef PWM_RAMP_BOUNCE_EN
        bounce_d = bounce_q;
        origin_d = origin_q;
`endif
        if (ext_wr_valid) begin
            // Direct write pre-empts everything; same-cycle start/abort are dropped.
            duty_d  = ext_wr_data;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (target == duty_q) begin
                            done_d = 1'b1;
                        end else begin
                            tgt_d   = target;
                            step_d  = (step == '0) ? DUTY_W'(1) : step;
                            intv_d  = interval;
                            cnt_d   = interval;
                            state_d = RAMP;
`ifdef PWM_RAMP_BOUNCE_EN
                            bounce_d = bounce;
                            origin_d = duty_q;
`endif
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state_d = IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - TICK_W'(1);
                    end else begin
                        duty_d = next_duty;
                        cnt_d  = intv_q;
                        if (next_duty == tgt_q) begin
                            done_d = 1'b1;
`ifdef PWM_RAMP_BOUNCE_EN
                            if (bounce_q) begin
                                // Head back to where this leg started.
                                tgt_d    = origin_q;
                                origin_d = tgt_q;
                            end else begin
                                state_d = IDLE;
                            end
`else
                            state_d = IDLE;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RAMP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            tgt_q    <= '0;
            step_q   <= '0;
            intv_q   <= '0;
`ifdef PWM_RAMP_BOUNCE_EN
            bounce_q <= 1'b0;
            origin_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            step_q   <= step_d;
            intv_q   <= intv_d;
`ifdef PWM_RAMP_BOUNCE_EN
            bounce_q <= bounce_d;
            origin_q <= origin_d;
`endif
        end
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Purpose: randomized and directed stimulus for pwm_ramp_sequencer against a timeline-level reference model.
// Latency: expectations are queued per driven cycle and checked a few ns after the following rising edge.
// Backpressure: none; the monitor consumes one expectation per edge whenever one is queued.
module tb_pwm_ramp_sequencer;

    typedef struct packed {
        logic [7:0] duty;
        logic       busy;
        logic       done;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  target;
    logic [7:0]  step;
    logic [15:0] interval;
    logic        ext_wr_valid;
    logic [7:0]  ext_wr_data;
    logic        bounce;
    logic [7:0]  duty_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;

    // Reference model: a ramp is expanded at acceptance into its whole future
    // per-edge output timeline; abort/ext write simply discard what remains.
    obs_t        sb[$];
    obs_t        plan[$];
    logic [7:0]  m_duty = 8'd0;
    bit          m_bnc = 1'b0;
    logic [7:0]  m_from, m_to, m_stp;
    logic [15:0] m_intv;

    always #5 clk = ~clk;

    pwm_ramp_sequencer #(.DUTY_W(8), .TICK_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .target       (target),
        .step         (step),
        .interval     (interval),
        .ext_wr_valid (ext_wr_valid),
        .ext_wr_data  (ext_wr_data),
`ifdef PWM_RAMP_BOUNCE_EN
        .bounce       (bounce),
`endif
        .duty_out     (duty_out),
        .busy         (busy),
        .done         (done)
    );

    // Each leg: interval holding edges, then one move of min(step, remaining distance).
    task automatic build_plan(input logic [7:0] from, input logic [7:0] to,
                              input logic [7:0] stp, input logic [15:0] intv, input bit bnc);
        int cur;
        int nxt;
        int s;
        obs_t e;
        cur = int'(from);
        s = (stp == 8'd0) ? 1 : int'(stp);
        while (cur != int'(to)) begin
            if (int'(to) > cur) nxt = (int'(to) - cur <= s) ? int'(to) : cur + s;
            else                nxt = (cur - int'(to) <= s) ? int'(to) : cur - s;
            for (int k = 0; k < int'(intv); k++) begin
                e.duty = 8'(cur); e.busy = 1'b1; e.done = 1'b0;
                plan.push_back(e);
            end
            e.duty = 8'(nxt);
            e.done = (nxt == int'(to));
            e.busy = (nxt == int'(to)) ? bnc : 1'b1;
            plan.push_back(e);
            cur = nxt;
        end
    endtask

    task automatic cycle(input bit st, input bit ab, input logic [7:0] tg, input logic [7:0] sp,
                         input logic [15:0] iv, input bit ew, input logic [7:0] ed, input bit bn);
        obs_t e;
        logic [7:0] tmp;
        @(negedge clk);
        start = st; abort = ab; target = tg; step = sp; interval = iv;
        ext_wr_valid = ew; ext_wr_data = ed; bounce = bn;
`ifndef PWM_RAMP_BOUNCE_EN
        bn = 1'b0;
`endif
        if (ew) begin
            plan.delete(); m_bnc = 1'b0; m_duty = ed;
            e.duty = ed; e.busy = 1'b0; e.done = 1'b0;
        end else if (plan.size() > 0) begin
            if (ab) begin
                plan.delete(); m_bnc = 1'b0;
                e.duty = m_duty; e.busy = 1'b0; e.done = 1'b0;
            end else begin
                e = plan.pop_front();
                m_duty = e.duty;
                if (plan.size() == 0 && m_bnc) begin
                    build_plan(m_to, m_from, m_stp, m_intv, 1'b1);
                    tmp = m_to; m_to = m_from; m_from = tmp;
                end
            end
        end else if (st) begin
            if (tg == m_duty) begin
                e.duty = m_duty; e.busy = 1'b0; e.done = 1'b1;
            end else begin
                m_from = m_duty; m_to = tg; m_stp = sp; m_intv = iv; m_bnc = bn;
                build_plan(m_duty, tg, sp, iv, bn);
                e.duty = m_duty; e.busy = 1'b1; e.done = 1'b0;
            end
        end else begin
            e.duty = m_duty; e.busy = 1'b0; e.done = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'd0, 8'd0, 16'd0, 0, 8'd0, 0);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    task automatic model_reset();
        plan.delete(); m_duty = 8'd0; m_bnc = 1'b0;
    endtask

    // Monitor: one queued expectation per rising edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (duty_out === e.duty && busy === e.busy && done === e.done) passes++;
                else $display("FAIL cyc t=%0t got duty=%0d busy=%0b done=%0b want duty=%0d busy=%0b done=%0b",
                              $time, duty_out, busy, done, e.duty, e.busy, e.done);
            end
        end
    end

    initial begin
        logic [7:0] tg;
        logic [7:0] sp;
        rst = 1'b1; start = 0; abort = 0; target = 0; step = 0; interval = 0;
        ext_wr_valid = 0; ext_wr_data = 0; bounce = 0;
        #1;
        chk("rst_duty", duty_out, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(5);

        // Up ramp 0 -> 10, step 3, interval 2.
        cycle(1, 0, 8'd10, 8'd3, 16'd2, 0, 8'd0, 0);
        idle(14);

        // Down ramp with clamp from 200 to 0, step 128.
        cycle(0, 0, 8'd0, 8'd0, 16'd0, 1, 8'd200, 0);
        cycle(1, 0, 8'd0, 8'd128, 16'd0, 0, 8'd0, 0);
        idle(4);

        // Zero step behaves as one; abort at duty 5; then start at current value.
        cycle(1, 0, 8'd50, 8'd0, 16'd0, 0, 8'd0, 0);
        idle(5);
        cycle(0, 1, 8'd0, 8'd0, 16'd0, 0, 8'd0, 0);
        idle(2);
        cycle(1, 0, 8'd5, 8'd1, 16'd0, 0, 8'd0, 0);
        idle(3);

        // Arbitration: ext write with start and abort in the same cycle mid-ramp.
        cycle(1, 0, 8'd200, 8'd1, 16'd1, 0, 8'd0, 0);
        idle(4);
        cycle(1, 1, 8'd10, 8'd1, 16'd0, 1, 8'h80, 0);
        idle(3);

`ifdef PWM_RAMP_BOUNCE_EN
        // Bounce between 20 and 24.
        cycle(0, 0, 8'd0, 8'd0, 16'd0, 1, 8'd20, 0);
        cycle(1, 0, 8'd24, 8'd2, 16'd0, 0, 8'd0, 1);
        idle(8);
        cycle(0, 1, 8'd0, 8'd0, 16'd0, 0, 8'd0, 0);
        idle(3);
`endif

        // Asynchronous reset mid-ramp, checked before any further edge.
        cycle(1, 0, 8'd250, 8'd7, 16'd1, 0, 8'd0, 0);
        idle(4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_duty", duty_out, 8'd0);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_done", {7'd0, done}, 8'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tg = ($urandom % 8 == 0) ? m_duty : 8'($urandom);
            sp = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            cycle(($urandom % 6) == 0, ($urandom % 40) == 0, tg, sp, 16'($urandom % 4),
                  ($urandom % 70) == 0, 8'($urandom), ($urandom % 3) == 0);
        end
        idle(2);

        @(posedge clk);
        #5;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL sb_drain got=%0d want=0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
